// File: rtl/unary_add_pkg.sv
// Shared types and constants for the unary add/drain transaction controller.
package unary_add_pkg;

  localparam int unsigned UA_CNT_W = 9;
  localparam int unsigned UA_PH_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } ua_ctrl_state_t;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned ua_id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ua_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module ua_rr_arb
  import unary_add_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = ua_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [ID_W-1:0]    idx_c_o,
  output logic               valid_c_o
);

  int unsigned cand;

  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      if (!valid_c_o && req_i[ID_W'(cand)]) begin
        valid_c_o              = 1'b1;
        idx_c_o                = ID_W'(cand);
        gnt_c_o[ID_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unary_add_ctrl.sv
// Shares one unary add/drain core among NUM_REQ requesters: arbitrate, accumulate
// for ACC_LEN cycles, drain the core back to binary, return the count on a valid/ready port.
module unary_add_ctrl
  import unary_add_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned CNT_W   = UA_CNT_W,
  parameter  int unsigned ACC_LEN = 16,
  localparam int unsigned ID_W    = ua_id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] a_in_i,
  input  logic [NUM_REQ-1:0] b_in_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               add_en_o,
  output logic               add_rw_o,
  output logic               add_a_o,
  output logic               add_b_o,
  input  logic               add_dout_i,
  input  logic               add_c_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [CNT_W-1:0]   res_data_o,
  output logic               res_ovf_o,
  output logic [ID_W-1:0]    res_id_o,
  output logic               busy_o
);

  localparam logic [UA_PH_W-1:0] ACC_LAST = UA_PH_W'(ACC_LEN - 1);

  ua_ctrl_state_t       state_q, state_d;
  logic [ID_W-1:0]      gid_q, gid_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [UA_PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;

  ua_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (req_i),
    .ptr_i     (rr_q),
    .gnt_c_o   (arb_gnt),
    .idx_c_o   (arb_idx),
    .valid_c_o (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next state plus core steering decoded from the current state.
  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    rr_d        = rr_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    gnt_d       = gnt_q;
    add_en_o    = 1'b0;
    add_rw_o    = 1'b0;
    add_a_o     = 1'b0;
    add_b_o     = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_ACC;
          gid_d   = arb_idx;
          gnt_d   = arb_gnt;
          ph_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ACC: begin
        add_en_o = 1'b1;
        add_a_o  = a_in_i[gid_q];
        add_b_o  = b_in_i[gid_q];
        ovf_d    = ovf_q | add_c_i;
        if (ph_q == ACC_LAST) begin
          ph_d    = '0;
          state_d = ST_DRAIN;
        end else begin
          ph_d = ph_q + UA_PH_W'(1);
        end
      end
      ST_DRAIN: begin
        add_en_o = 1'b1;
        add_rw_o = 1'b1;
        ovf_d    = ovf_q | add_c_i;
        // ph_q == 0 marks the first drain cycle, where the core output is still stale.
        if (ph_q == '0) begin
          ph_d = UA_PH_W'(1);
        end else if (add_dout_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          rr_d    = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_o      = gnt_q;
  assign res_data_o = cnt_q;
  assign res_ovf_o  = ovf_q;
  assign res_id_o   = gid_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_unary_add_ctrl.sv
// Bench for unary_add_ctrl with a behavioural 9-bit unary add/drain core per instance.
module tb_unary_add_ctrl;

  localparam int N     = 4;
  localparam int W     = 9;
  localparam int LEN_A = 16;
  localparam int LEN_B = 300;

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
    logic [1:0]   id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Instance A (ACC_LEN=16)
  logic [N-1:0] req, a_in, b_in, gnt;
  logic         add_en, add_rw, add_a, add_b, add_dout, add_c;
  logic         res_valid, res_ready, res_ovf, busy;
  logic [W-1:0] res_data;
  logic [1:0]   res_id;

  // Instance B (ACC_LEN=300)
  logic [N-1:0] ob_req, ob_a, ob_b, ob_gnt;
  logic         ob_en, ob_rw, ob_add_a, ob_add_b, ob_dout, ob_c;
  logic         ob_valid, ob_ready, ob_ovf, ob_busy;
  logic [W-1:0] ob_data;
  logic [1:0]   ob_id;

  unary_add_ctrl #(.NUM_REQ(N), .CNT_W(W), .ACC_LEN(LEN_A)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .a_in_i(a_in), .b_in_i(b_in), .gnt_o(gnt),
    .add_en_o(add_en), .add_rw_o(add_rw), .add_a_o(add_a), .add_b_o(add_b),
    .add_dout_i(add_dout), .add_c_i(add_c), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_ovf_o(res_ovf), .res_id_o(res_id), .busy_o(busy)
  );

  unary_add_ctrl #(.NUM_REQ(N), .CNT_W(W), .ACC_LEN(LEN_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(ob_req), .a_in_i(ob_a), .b_in_i(ob_b), .gnt_o(ob_gnt),
    .add_en_o(ob_en), .add_rw_o(ob_rw), .add_a_o(ob_add_a), .add_b_o(ob_add_b),
    .add_dout_i(ob_dout), .add_c_i(ob_c), .res_valid_o(ob_valid), .res_ready_i(ob_ready),
    .res_data_o(ob_data), .res_ovf_o(ob_ovf), .res_id_o(ob_id), .busy_o(ob_busy)
  );

  // Core models: accumulate a+b while reading, emit one registered dout pulse per count while draining.
  logic [1:0]   cen, crw, ca, cb, cdout, cc;
  logic [W-1:0] ccnt [2];
  assign cen = {ob_en, add_en};
  assign crw = {ob_rw, add_rw};
  assign ca  = {ob_add_a, add_a};
  assign cb  = {ob_add_b, add_b};
  assign add_dout = cdout[0];
  assign add_c    = cc[0];
  assign ob_dout  = cdout[1];
  assign ob_c     = cc[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt[0] <= '0;
      ccnt[1] <= '0;
      cdout   <= '0;
      cc      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cdout[i] <= 1'b0;
        cc[i]    <= 1'b0;
        if (cen[i] && !crw[i]) begin
          ccnt[i] <= ccnt[i] + W'(ca[i]) + W'(cb[i]);
          cc[i]   <= (10'(ccnt[i]) + 10'(ca[i]) + 10'(cb[i])) > 10'd511;
        end else if (cen[i] && crw[i] && ccnt[i] != '0) begin
          cdout[i] <= 1'b1;
          ccnt[i]  <= ccnt[i] - W'(1);
        end
      end
    end
  end

  function automatic int pulse(input int mode, input int c);
    if (mode == 1) return 1;
    if (mode == 2) return (c % 2 == 0) ? 1 : 0;
    return 0;
  endfunction

  // One transaction on instance A: drive streams, hold RESP for `hold` cycles, then accept.
  task automatic do_txn(input int id, input int amode, input int bmode, input int hold,
                        output int vcyc, output int dlen);
    int         k;
    int         cyc;
    exp_t       e;
    exp_t       got;
    logic [1:0] ix;
    logic [W-1:0] held;
    ix = 2'(id);
    k  = 0;
    for (int c = 1; c <= LEN_A; c++) k += pulse(amode, c) + pulse(bmode, c);
    e.data = W'(k);
    e.ovf  = (k > 511);
    e.id   = ix;
    sb.push_back(e);
    vcyc = -1;
    dlen = 0;
    cyc  = 0;
    req[ix]  = 1'b1;
    a_in[ix] = 1'b0;
    b_in[ix] = 1'b0;
    while (vcyc < 0 && cyc < LEN_A + 600) begin
      @(negedge clk);
      cyc++;
      if (res_valid) vcyc = cyc;
      else if (add_en && add_rw) dlen++;
      a_in[ix] = (cyc <= LEN_A) && (pulse(amode, cyc) != 0);
      b_in[ix] = (cyc <= LEN_A) && (pulse(bmode, cyc) != 0);
    end
    checks++;
    if (vcyc < 0) begin
      errors++;
      $display("FAIL txn_timeout id=%0d: res_valid not seen within %0d cycles", id, cyc);
      void'(sb.pop_back());
    end else begin
      got = {res_data, res_ovf, res_id};
      e   = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL txn_result id=%0d: got data=%0d ovf=%0b id=%0d, want data=%0d ovf=%0b id=%0d",
                 id, got.data, got.ovf, got.id, e.data, e.ovf, e.id);
      end
      checks++;
      if (gnt !== (4'b0001 << ix)) begin
        errors++;
        $display("FAIL txn_gnt id=%0d: got %b want %b", id, gnt, 4'b0001 << ix);
      end
      held = res_data;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== held || add_en !== 1'b0 || gnt !== (4'b0001 << ix)) begin
          errors++;
          $display("FAIL resp_hold cyc=%0d: valid=%b data=%0d en=%b gnt=%b, want valid=1 data=%0d en=0 gnt=%b",
                   h, res_valid, res_data, add_en, gnt, held, 4'b0001 << ix);
        end
      end
    end
    res_ready = 1'b1;
    req[ix]   = 1'b0;
    a_in[ix]  = 1'b0;
    b_in[ix]  = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL txn_release id=%0d: valid=%b gnt=%b, want 0 and 0000", id, res_valid, gnt);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
    ob_req = '0; ob_a = '0; ob_b = '0; ob_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, add_en, add_rw, add_a, add_b, res_valid, res_data, res_ovf, res_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: gnt=%b en=%b rw=%b v=%b data=%0d ovf=%b id=%0d busy=%b, want all 0",
               gnt, add_en, add_rw, res_valid, res_data, res_ovf, res_id, busy);
    end
    checks++;
    if ({ob_gnt, ob_en, ob_rw, ob_add_a, ob_add_b, ob_valid, ob_data, ob_ovf, ob_id, ob_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: gnt=%b en=%b v=%b data=%0d busy=%b, want all 0",
               ob_gnt, ob_en, ob_valid, ob_data, ob_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int   seen;
    int   cyc;
    int   last;
    int   bad;
    int   expgap;
    int   ids[5];
    exp_t e;
    exp_t got;
    ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      e.data = W'(LEN_A * ((ids[i] % 2 == 1) ? 2 : 1));
      e.ovf  = 1'b0;
      e.id   = 2'(ids[i]);
      sb.push_back(e);
    end
    seen = 0; cyc = 0; last = 0; bad = 0;
    a_in = 4'b1111; b_in = 4'b1010; res_ready = 1'b1; req = 4'b1111;
    while (seen < 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (!$onehot0(gnt) || (busy && !$onehot(gnt))) bad++;
      if (res_valid) begin
        e   = sb.pop_front();
        got = {res_data, res_ovf, res_id};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL rr_result #%0d: got data=%0d ovf=%0b id=%0d, want data=%0d ovf=%0b id=%0d",
                   seen, got.data, got.ovf, got.id, e.data, e.ovf, e.id);
        end
        expgap = (seen == 0) ? LEN_A + int'(e.data) + 3 : LEN_A + int'(e.data) + 4;
        checks++;
        if (cyc - last !== expgap) begin
          errors++;
          $display("FAIL rr_spacing #%0d: got %0d cycles want %0d", seen, cyc - last, expgap);
        end
        last = cyc;
        seen++;
        if (seen == 5) req = '0;
      end
    end
    checks++;
    if (seen !== 5) begin
      errors++;
      $display("FAIL rr_count: got %0d responses want 5", seen);
      while (sb.size() > 0) void'(sb.pop_front());
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rr_onehot: %0d cycles with bad gnt, want 0", bad);
    end
    @(negedge clk);
    res_ready = 1'b0; a_in = '0; b_in = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int vc;
    int dl;
    req[3] = 1'b1;
    do_txn(2, 1, 0, 5, vc, dl);
    req[3] = 1'b0;
    checks++;
    if (vc !== LEN_A + 16 + 3) begin
      errors++;
      $display("FAIL bp_valid_cycle: got %0d want %0d", vc, LEN_A + 19);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL bp_no_restart: busy=%b gnt=%b want 0 and 0000", busy, gnt);
    end
  endtask

  task automatic test_single();
    int vc;
    int dl;
    do_txn(1, 1, 2, 0, vc, dl);
    checks++;
    if (vc !== 43) begin
      errors++;
      $display("FAIL single_valid_cycle: got %0d want 43", vc);
    end
    checks++;
    if (dl !== 26) begin
      errors++;
      $display("FAIL single_drain_len: got %0d want 26", dl);
    end
  endtask

  task automatic test_zero();
    int vc;
    int dl;
    do_txn(0, 0, 0, 0, vc, dl);
    checks++;
    if (vc !== 19) begin
      errors++;
      $display("FAIL zero_valid_cycle: got %0d want 19", vc);
    end
    checks++;
    if (dl !== 2) begin
      errors++;
      $display("FAIL zero_drain_len: got %0d want 2", dl);
    end
  endtask

  task automatic test_reset_mid_drain();
    int vc;
    int dl;
    req[3] = 1'b1;
    a_in[3] = 1'b0;
    for (int cyc = 1; cyc <= LEN_A + 3; cyc++) begin
      @(negedge clk);
      a_in[3] = (cyc <= LEN_A);
    end
    checks++;
    if (add_en !== 1'b1 || add_rw !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain_state: en=%b rw=%b want 1 1", add_en, add_rw);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, add_en, add_rw, add_a, add_b, res_valid, res_data, res_ovf, res_id, busy} !== '0) begin
      errors++;
      $display("FAIL mid_drain_reset: gnt=%b en=%b rw=%b v=%b data=%0d ovf=%b id=%0d busy=%b, want all 0",
               gnt, add_en, add_rw, res_valid, res_data, res_ovf, res_id, busy);
    end
    @(negedge clk);
    req = '0; a_in = '0; b_in = '0;
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(3, 2, 1, 0, vc, dl);
    checks++;
    if (vc !== 43) begin
      errors++;
      $display("FAIL post_reset_valid_cycle: got %0d want 43", vc);
    end
  endtask

  task automatic test_overflow();
    int   cyc;
    exp_t e;
    exp_t got;
    e.data = W'(88);
    e.ovf  = 1'b1;
    e.id   = 2'd0;
    sb.push_back(e);
    ob_req = 4'b0001; ob_a = 4'b0001; ob_b = 4'b0001;
    cyc = 0;
    while (!ob_valid && cyc < 1200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== LEN_B + 88 + 3) begin
      errors++;
      $display("FAIL ovf_valid_cycle: got %0d want %0d", cyc, LEN_B + 91);
    end
    got = {ob_data, ob_ovf, ob_id};
    e   = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ovf_result: got data=%0d ovf=%0b id=%0d, want data=%0d ovf=%0b id=%0d",
               got.data, got.ovf, got.id, e.data, e.ovf, e.id);
    end
    ob_ready = 1'b1; ob_req = '0; ob_a = '0; ob_b = '0;
    @(negedge clk);
    ob_ready = 1'b0;
    checks++;
    if (ob_valid !== 1'b0 || ob_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_release: valid=%b gnt=%b want 0 and 0000", ob_valid, ob_gnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single();
    test_zero();
    test_reset_mid_drain();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
